// File: rtl/bip_pkg.sv
// Shared encodings for the BIPI control unit:
// opcodes, FSM states, mux selects and field positions.
package bip_pkg;

  localparam int PC_W    = 11;
  localparam int OPC_W   = 5;
  localparam int OPR_W   = 11;
  localparam int INSTR_W = 16;
  localparam int CYC_W   = 32;

  localparam int OPC_LSB = 11;
  localparam int OPR_LSB = 0;

  localparam logic [OPC_W-1:0] OP_HLT  = 5'd0;
  localparam logic [OPC_W-1:0] OP_STO  = 5'd1;
  localparam logic [OPC_W-1:0] OP_LD   = 5'd2;
  localparam logic [OPC_W-1:0] OP_LDI  = 5'd3;
  localparam logic [OPC_W-1:0] OP_ADD  = 5'd4;
  localparam logic [OPC_W-1:0] OP_ADDI = 5'd5;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'd6;
  localparam logic [OPC_W-1:0] OP_SUBI = 5'd7;

  localparam logic [1:0] SELA_MEM = 2'd0;
  localparam logic [1:0] SELA_IMM = 2'd1;
  localparam logic [1:0] SELA_ALU = 2'd2;

  localparam logic SELB_MEM = 1'b0;
  localparam logic SELB_IMM = 1'b1;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_LOAD_IR,
    ST_OPERAND,
    ST_EXEC,
    ST_HALT
  } state_t;

  typedef struct packed {
    logic [1:0] sel_a;
    logic       sel_b;
    logic       wr_acc;
    logic       wr_ram;
    logic       rd_ram;
    logic       is_halt;
  } dec_t;

endpackage

// File: rtl/bip_control_unit_if.sv
// Control-unit bus towards program memory, datapath,
// data memory and the debug unit.
interface bip_control_unit_if;
  import bip_pkg::*;

  logic               i_enable;
  logic [INSTR_W-1:0] i_instruction;
  logic [PC_W-1:0]    o_pc_addr;
  logic [OPC_W-1:0]   o_opcode;
  logic [OPR_W-1:0]   o_operando;
  logic [1:0]         o_selA;
  logic               o_selB;
  logic               o_wrACC;
  logic               o_wrRAM;
  logic               o_rdRAM;
  logic               o_halt;
  logic [CYC_W-1:0]   o_cycles;

  modport master (
    input  i_enable, i_instruction,
    output o_pc_addr, o_opcode, o_operando,
    output o_selA, o_selB,
    output o_wrACC, o_wrRAM, o_rdRAM,
    output o_halt, o_cycles
  );

  modport slave (
    output i_enable, i_instruction,
    input  o_pc_addr, o_opcode, o_operando,
    input  o_selA, o_selB,
    input  o_wrACC, o_wrRAM, o_rdRAM,
    input  o_halt, o_cycles
  );

endinterface

// File: rtl/bip_instruction_decoder.sv
// Combinational opcode decode into mux selects,
// strobe enables and the halt flag.
module bip_instruction_decoder
  import bip_pkg::*;
#(
  parameter int OPCODE_LENGTH = OPC_W
) (
  input  logic [OPCODE_LENGTH-1:0] i_opcode,
  output dec_t                     o_dec
);

  logic [OPC_W-1:0] w_op;

  assign w_op = OPC_W'(i_opcode);

  always_comb begin
    o_dec = '0;
    unique case (1'b1)
      (w_op == OP_HLT): begin
        o_dec.is_halt = 1'b1;
      end
      (w_op == OP_STO): begin
        o_dec.wr_ram = 1'b1;
      end
      (w_op == OP_LD): begin
        o_dec.sel_a  = SELA_MEM;
        o_dec.wr_acc = 1'b1;
        o_dec.rd_ram = 1'b1;
      end
      (w_op == OP_LDI): begin
        o_dec.sel_a  = SELA_IMM;
        o_dec.wr_acc = 1'b1;
      end
      (w_op == OP_ADD) || (w_op == OP_SUB): begin
        o_dec.sel_a  = SELA_ALU;
        o_dec.sel_b  = SELB_MEM;
        o_dec.wr_acc = 1'b1;
        o_dec.rd_ram = 1'b1;
      end
      (w_op == OP_ADDI) || (w_op == OP_SUBI): begin
        o_dec.sel_a  = SELA_ALU;
        o_dec.sel_b  = SELB_IMM;
        o_dec.wr_acc = 1'b1;
      end
      default: begin
        o_dec = '0;
      end
    endcase
  end

endmodule

// File: rtl/bip_control_unit.sv
// BIPI multi-cycle control unit: PC, IR, cycle counter
// and the FETCH/LOAD_IR/OPERAND/EXEC/HALT sequencer.
module bip_control_unit
  import bip_pkg::*;
#(
  parameter int PC_LENGTH       = PC_W,
  parameter int OPCODE_LENGTH   = OPC_W,
  parameter int OPERANDO_LENGTH = OPR_W,
  parameter int INSTR_LENGTH    = INSTR_W,
  parameter int CYCLES_LENGTH   = CYC_W
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_enable,
  input  logic [INSTR_LENGTH-1:0]    i_instruction,
  output logic [PC_LENGTH-1:0]       o_pc_addr,
  output logic [OPCODE_LENGTH-1:0]   o_opcode,
  output logic [OPERANDO_LENGTH-1:0] o_operando,
  output logic [1:0]                 o_selA,
  output logic                       o_selB,
  output logic                       o_wrACC,
  output logic                       o_wrRAM,
  output logic                       o_rdRAM,
  output logic                       o_halt,
  output logic [CYCLES_LENGTH-1:0]   o_cycles
);

  state_t                     r_state;
  state_t                     w_next;
  logic [PC_LENGTH-1:0]       r_pc;
  logic [INSTR_LENGTH-1:0]    r_ir;
  logic [CYCLES_LENGTH-1:0]   r_cycles;
  logic [OPCODE_LENGTH-1:0]   w_opcode;
  dec_t                       w_dec;
  logic                       w_in_op;
  logic                       w_in_ex;
  logic                       w_go;

  assign w_opcode = r_ir[OPC_LSB +: OPCODE_LENGTH];
  assign w_in_op  = (r_state == ST_OPERAND);
  assign w_in_ex  = (r_state == ST_EXEC);
  // A reset cycle never lets a strobe through to memory or ACC.
  assign w_go     = i_enable & ~i_reset;

  bip_instruction_decoder #(
    .OPCODE_LENGTH (OPCODE_LENGTH)
  ) u_dec (
    .i_opcode (w_opcode),
    .o_dec    (w_dec)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= ST_FETCH;
    end else if (i_enable) begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    o_selA  = SELA_MEM;
    o_selB  = SELB_MEM;
    o_wrACC = 1'b0;
    o_wrRAM = 1'b0;
    o_rdRAM = 1'b0;
    unique case (r_state)
      ST_FETCH: begin
        w_next = ST_LOAD_IR;
      end
      ST_LOAD_IR: begin
        w_next = ST_OPERAND;
      end
      ST_OPERAND: begin
        w_next  = w_dec.is_halt ? ST_HALT : ST_EXEC;
        o_selA  = w_dec.sel_a;
        o_selB  = w_dec.sel_b;
        o_rdRAM = w_go & w_dec.rd_ram;
      end
      ST_EXEC: begin
        w_next  = ST_FETCH;
        o_selA  = w_dec.sel_a;
        o_selB  = w_dec.sel_b;
        o_wrACC = w_go & w_dec.wr_acc;
        o_wrRAM = w_go & w_dec.wr_ram;
      end
      ST_HALT: begin
        w_next = ST_HALT;
      end
      default: begin
        w_next = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_pc     <= '0;
      r_ir     <= '0;
      r_cycles <= '0;
    end else if (i_enable) begin
      if (r_state == ST_LOAD_IR) begin
        r_ir <= i_instruction;
      end
      if (w_in_ex) begin
        r_pc <= r_pc + PC_LENGTH'(1);
      end
      if (r_state != ST_HALT) begin
        r_cycles <= r_cycles + CYCLES_LENGTH'(1);
      end
    end
  end

  assign o_pc_addr  = r_pc;
  assign o_opcode   = w_opcode;
  assign o_operando = r_ir[OPR_LSB +: OPERANDO_LENGTH];
  assign o_halt     = (r_state == ST_HALT);
  assign o_cycles   = r_cycles;

endmodule

// File: doc/bip_control_unit.md
# bip_control_unit

Multi-cycle control unit for the BIPI accumulator processor. Holds the program counter and instruction register, and fetches from the synchronous program memory. Decodes the opcode and sequences the datapath through its `i_selA`, `i_selB`, `i_wrACC` and `i_opcode` inputs, plus the data-memory strobes. Sits between program memory, datapath and data memory; a debug unit gates it through `i_enable` and reads `o_halt` and `o_cycles`.

## Interface
- `PC_LENGTH`, 11, program counter and program-memory address width
- `OPCODE_LENGTH`, 5, opcode field width, instruction bits [15:11]
- `OPERANDO_LENGTH`, 11, operand field width, instruction bits [10:0]
- `INSTR_LENGTH`, 16, instruction word width
- `CYCLES_LENGTH`, 32, cycle counter width
- One clock; reset is synchronous and active-high.
- `i_clock`  in  1  system clock
- `i_reset`  in  1  synchronous, active-high reset
- `i_enable`  in  1  advance when 1; freeze when 0
- `i_instruction`  in  INSTR_LENGTH  program-memory read data, valid one cycle after `o_pc_addr`
- `o_pc_addr`  out  PC_LENGTH  program-memory address (= PC)
- `o_opcode`  out  OPCODE_LENGTH  IR opcode to datapath
- `o_operando`  out  OPERANDO_LENGTH  IR operand to datapath (immediate / data address)
- `o_selA`  out  2  ACC source: 0 data mem, 1 sign-extended operand, 2 ALU
- `o_selB`  out  1  ALU operand B: 0 data mem, 1 operand
- `o_wrACC`  out  1  ACC write strobe
- `o_wrRAM`  out  1  data-memory write strobe
- `o_rdRAM`  out  1  data-memory read strobe
- `o_halt`  out  1  processor halted
- `o_cycles`  out  CYCLES_LENGTH  executed-cycle count

## Operation
- FSM states: FETCH, LOAD_IR, OPERAND, EXEC, HALT.
- FETCH: present PC on `o_pc_addr` → LOAD_IR.
- LOAD_IR: `i_instruction` valid; IR <= `i_instruction` at end of cycle → OPERAND.
- OPERAND: IR fields drive `o_opcode` and `o_operando`. `o_rdRAM`=1 for opcodes 2, 4, 6.
  - Opcode 0 → HALT; otherwise → EXEC.
- EXEC: one-cycle write strobe per decode; PC <= PC+1 → FETCH.
- HALT: sticky until reset; no strobes; PC frozen.
- Decode (`o_selA`, `o_selB` held from OPERAND through EXEC; strobes in EXEC only):
  - 1 STO: `o_wrRAM`=1.
  - 2 LD: selA=0, `o_wrACC`=1.
  - 3 LDI: selA=1, `o_wrACC`=1.
  - 4 ADD: selA=2, selB=0, `o_wrACC`=1.
  - 5 ADDI: selA=2, selB=1, `o_wrACC`=1.
  - 6 SUB: selA=2, selB=0, `o_wrACC`=1.
  - 7 SUBI: selA=2, selB=1, `o_wrACC`=1.
  - 8–31: NOP (no strobes, PC increments).
- Outside the listed cases, `o_selA`/`o_selB` are 0.
- PC is PC_LENGTH bits and wraps 2047 → 0.
- `o_cycles` increments every clock with `i_enable`=1 and state ≠ HALT; wraps at max.

## Timing
- Reset values: state FETCH, PC 0, IR 0, all strobes 0, `o_selA`/`o_selB` 0, `o_halt` 0, `o_cycles` 0.
- Fixed 4 cycles per instruction. The first EXEC strobe comes 3 enabled cycles after reset release.
- Strobes are registered or decoded from the registered state only; they are never combinational from `i_instruction`.
- `i_enable`=0:
  - State, PC, IR and counter hold.
  - `o_wrACC`, `o_wrRAM` and `o_rdRAM` are forced 0.
  - On resume, an EXEC frozen mid-stall re-issues its strobe exactly once, on the first enabled EXEC cycle.
- `o_halt` rises on the cycle after OPERAND decodes opcode 0.
- Reset has priority over `i_enable` and all state. Reset asserted in EXEC suppresses the write: strobes are 0 in the cycle after the reset edge.

## Structure
- Package `bip_pkg`:
  - opcode localparams (HLT..SUBI)
  - FSM state encoding
  - selA encodings (SELA_MEM, SELA_IMM, SELA_ALU) and selB encodings
  - field bit positions
- Sub-module `bip_instruction_decoder`: combinational opcode → {selA, selB, wrACC, wrRAM, rdRAM, is_halt}.
- The top holds the FSM, PC, IR and counter.

## Test plan
- Reset then program {0x1005 (LD 5), 0x2003 (ADD 3), 0x0000 (HLT)} → `o_pc_addr` 0,1,2 with 4-cycle spacing:
  - LD: `o_wrACC` pulse with selA=0.
  - ADD: `o_wrACC` pulse with selA=2, selB=0.
  - HLT: `o_halt`=1, PC frozen at 2; `o_cycles`=11 and constant afterward.
- All opcodes 1–7 → each strobe and sel value matches the decode list; `o_rdRAM` pulses in OPERAND only for 2, 4, 6.
- `i_enable` low for 5 cycles during EXEC of ADDI → no strobe while stalled; exactly one `o_wrACC` on resume; `o_cycles` excludes stalled cycles.
- PC preset to 2047 via a NOP program → next `o_pc_addr`=0; opcode 0x1F runs as NOP with no strobes.
- `i_reset` asserted during EXEC of STO → no `o_wrRAM` after the reset edge; PC 0, state FETCH, `o_cycles` 0.
